// File: rtl/ltc2315_emulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2315_pkg
//  Description : Shared types and constants for the LTC2315 read-interface
//                emulator and the matching LTC2315 driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package ltc2315_pkg;

  // Converter word and frame geometry
  localparam int LTC2315_DATA_W     = 12;
  localparam int LTC2315_FRAME_BITS = 14;  // leading 0 + 12 data + trailing 0

  // Bit-position counter: 4 bits, saturating so long frames keep reading 0
  localparam int               LTC2315_BCNT_W         = 4;
  localparam logic [3:0]       LTC2315_BCNT_MAX       = 4'd15;
  localparam logic [3:0]       LTC2315_FIRST_DATA_BIT = 4'd1;   // D11
  localparam logic [3:0]       LTC2315_LAST_DATA_BIT  = 4'd12;  // D0

  // Timing constants the driver relies on (in fabric clk cycles)
  localparam int LTC2315_SYNC_LATENCY    = 3;  // pin edge to registered reaction
  localparam int LTC2315_SCK_MIN_HALF    = 4;  // min SCK high / low phase
  localparam int LTC2315_CS_HIGH_MARGIN  = 3;  // cs high >= CONV_CYCLES + this

  // Responder state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CONV  = 2'd2
  } emu_state_t;

  // Value driven on miso for a given bit position of a normal frame:
  // position 0 is the leading zero, 1..12 carry D11..D0, the rest are zero.
  function automatic logic frame_bit(input logic [LTC2315_DATA_W-1:0] data,
                                     input logic [LTC2315_BCNT_W-1:0] bcnt);
    logic b;
    b = 1'b0;
    if ((bcnt >= LTC2315_FIRST_DATA_BIT) && (bcnt <= LTC2315_LAST_DATA_BIT)) begin
      b = data[LTC2315_LAST_DATA_BIT - bcnt];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ltc2315_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2315_emulator_if
//  Description : Pin-side (cs/sck/miso) and sample-side (valid/ready) signals
//                of the LTC2315 emulator. The emulator uses the slave view;
//                the controller plus sample source use the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ltc2315_emulator_if;
  import ltc2315_pkg::*;

  // Serial read interface from the external controller
  logic                      cs;
  logic                      sck;
  logic                      miso;
  logic                      miso_oe;

  // Sample source handshake
  logic [LTC2315_DATA_W-1:0] sample_data;
  logic                      sample_valid;
  logic                      sample_ready;

  // Status pulses
  logic                      underrun;
  logic                      early_read;

  modport slave (
    input  cs,
    input  sck,
    input  sample_data,
    input  sample_valid,
    output miso,
    output miso_oe,
    output sample_ready,
    output underrun,
    output early_read
  );

  modport master (
    output cs,
    output sck,
    output sample_data,
    output sample_valid,
    input  miso,
    input  miso_oe,
    input  sample_ready,
    input  underrun,
    input  early_read
  );

endinterface
`default_nettype wire

// File: rtl/ltc2315_emulator_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2315_pin_sync
//  Description : Two-flop synchronizer for an asynchronous controller pin,
//                followed by a history flop for rise/fall detection. The
//                reset value is the pin's idle level so that reset never
//                produces a phantom edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltc2315_pin_sync #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one flop of history for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/ltc2315_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : ltc2315_emulator
//  Description : Responder emulating the LTC2315 12-bit ADC serial read
//                interface. A cs rise starts a conversion (capturing the next
//                sample from the valid/ready source), CONV_CYCLES later the
//                result becomes readable, and a cs low frame shifts it out on
//                miso as 0, D11..D0, then zeros. Reading before the
//                conversion finishes yields an all-zero frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module ltc2315_emulator
  import ltc2315_pkg::*;
#(
  parameter int CONV_CYCLES = 44   // legal range 1..255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ltc2315_emulator_if.slave      bus
);

  // Down-counter start value; the counter sits at 0 for one cycle before the
  // return to IDLE, which gives CONV_CYCLES cycles of conversion in total.
  localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Pin synchronization
  // --------------------------------------------------------------------------
  logic cs_lvl;
  logic cs_rise;
  logic cs_fall;
  logic sck_fall;
  logic sck_lvl_unused;
  logic sck_rise_unused;

  ltc2315_pin_sync #(
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (bus.cs),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  ltc2315_pin_sync #(
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (bus.sck),
    .level_o (sck_lvl_unused),
    .rise_o  (sck_rise_unused),
    .fall_o  (sck_fall)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  emu_state_t                  state_q, state_d;
  logic [LTC2315_BCNT_W-1:0]   bcnt_q,  bcnt_d;
  logic [7:0]                  cnt_q,   cnt_d;
  logic [LTC2315_DATA_W-1:0]   conv_q,  conv_d;   // sample of the running conversion
  logic [LTC2315_DATA_W-1:0]   out_q,   out_d;    // completed, readable result
  logic                        zero_q,  zero_d;   // current frame is an early read
  logic                        miso_q,  miso_d;
  logic                        oe_q,    oe_d;
  logic                        ready_q, ready_d;
  logic                        under_q, under_d;
  logic                        early_q, early_d;

  // State, counters, data registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      conv_q  <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      under_q <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      conv_q  <= conv_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      under_q <= under_d;
      early_q <= early_d;
    end
  end

  // Next-state, sample capture, bit counting and miso selection
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ready_d = 1'b0;
    under_d = 1'b0;
    early_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Conversion done and cs high; a fall starts a normal read.
        if (cs_fall) begin
          state_d = SHIFT;
          bcnt_d  = '0;
          zero_d  = 1'b0;
        end
      end

      SHIFT: begin
        // cs rise beats a coincident sck fall: the frame ends (at any bit
        // position) and the next conversion starts with its sample capture.
        if (cs_rise) begin
          state_d = CONV;
          bcnt_d  = '0;
          cnt_d   = CONV_LOAD;
          if (bus.sample_valid) begin
            conv_d  = bus.sample_data;
            ready_d = 1'b1;
          end else begin
            under_d = 1'b1;
          end
        end else if (sck_fall && (bcnt_q != LTC2315_BCNT_MAX)) begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end

      CONV: begin
        // Reading during the conversion aborts it and serves zeros; the
        // captured sample stays in conv_q for the next conversion.
        if (cs_fall) begin
          state_d = SHIFT;
          bcnt_d  = '0;
          zero_d  = 1'b1;
          early_d = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
          out_d   = conv_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // miso tracks the bit position being entered this cycle, so a cs fall
    // presents bit 0 and each sck fall presents the next bit.
    miso_d = 1'b0;
    if ((state_d == SHIFT) && !zero_d) begin
      miso_d = frame_bit(out_q, bcnt_d);
    end

    oe_d = ~cs_lvl;
  end

  assign bus.miso         = miso_q;
  assign bus.miso_oe      = oe_q;
  assign bus.sample_ready = ready_q;
  assign bus.underrun     = under_q;
  assign bus.early_read   = early_q;

endmodule
`default_nettype wire

// File: tb/tb_ltc2315_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ltc2315_emulator
//  Description : Self-checking bench for ltc2315_emulator. Directed vectors
//                from a table, an async-reset sequence, then random frames
//                scored against a transaction-level model of the converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ltc2315_emulator;
  import ltc2315_pkg::*;

  localparam int CONV = 44;

  logic clk;
  logic reset_n;

  ltc2315_emulator_if bus();

  ltc2315_emulator #(
    .CONV_CYCLES (CONV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_ready = 0;
  int cnt_under = 0;
  int cnt_early = 0;

  // Transaction-level converter model: sample held by the running
  // conversion, and the value a completed conversion made readable.
  logic [11:0] m_conv;
  logic [11:0] m_out;

  typedef struct {
    bit          valid;
    logic [11:0] data;
    int          high;
    int          nbits;
    bit          early;
    logic [11:0] exp_read;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counting and the valid/ready rule, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.sample_ready) begin
      cnt_ready++;
      check("ready_without_valid", {31'd0, bus.sample_valid}, 32'd1);
    end
    if (bus.underrun)   cnt_under++;
    if (bus.early_read) cnt_early++;
  end

  // cs high phase: offers the sample, checks pulse timing, updates the model
  task automatic conv_phase(input bit valid, input logic [11:0] data, input int high,
                            output bit early);
    bus.sample_valid = valid;
    bus.sample_data  = data;
    bus.cs           = 1'b1;
    for (int k = 1; k <= high; k++) begin
      tick();
      if (k == 2)
        check("pulse_before_3clk", {31'd0, bus.sample_ready | bus.underrun}, 32'd0);
      if (k == 3) begin
        check("sample_ready_at_3clk", {31'd0, bus.sample_ready}, {31'd0, valid});
        check("underrun_at_3clk", {31'd0, bus.underrun}, {31'd0, ~valid});
      end
      if (k == 4)
        check("pulse_width", {31'd0, bus.sample_ready | bus.underrun}, 32'd0);
    end
    if (valid) m_conv = data;
    early = (high < CONV + LTC2315_CS_HIGH_MARGIN);
    if (!early) m_out = m_conv;
  endtask

  // cs low phase: checks enable/early timing and clocks out nbits at clk/8
  task automatic read_phase(input bit early_exp, input int nbits, output logic [15:0] got);
    got = 16'h0;
    bus.cs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2)
        check("miso_oe_before_3clk", {31'd0, bus.miso_oe}, 32'd0);
      if (k == 3) begin
        check("miso_oe_at_3clk", {31'd0, bus.miso_oe}, 32'd1);
        check("early_read_at_3clk", {31'd0, bus.early_read}, {31'd0, early_exp});
      end
    end
    for (int i = 0; i < nbits; i++) begin
      got[15-i] = bus.miso;
      bus.sck = 1'b1;
      repeat (4) tick();
      bus.sck = 1'b0;
      repeat (4) tick();
    end
  endtask

  // One conversion plus one read, compared to the supplied expectations
  task automatic run_txn(input string tag, input bit valid, input logic [11:0] data,
                         input int high, input int nbits, input bit use_model,
                         input bit t_early, input logic [11:0] t_read);
    int r0, u0, e0;
    bit m_early, exp_early;
    logic [15:0] got, exp_word, mask;
    r0 = cnt_ready; u0 = cnt_under; e0 = cnt_early;
    conv_phase(valid, data, high, m_early);
    exp_early = use_model ? m_early : t_early;
    exp_word  = exp_early ? 16'h0 : {1'b0, (use_model ? m_out : t_read), 3'b000};
    read_phase(exp_early, nbits, got);
    mask = ~(16'hFFFF >> nbits);
    check({tag, "_frame"}, {16'd0, got & mask}, {16'd0, exp_word & mask});
    check({tag, "_ready_count"}, cnt_ready - r0, {31'd0, valid});
    check({tag, "_underrun_count"}, cnt_under - u0, {31'd0, ~valid});
    check({tag, "_early_count"}, cnt_early - e0, {31'd0, exp_early});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    bit          dummy;
    int          r0, u0, e0;

    //                valid  data     high nbits early exp_read
    tbl[0] = '{1'b1, 12'hA5C, 60, 16, 1'b0, 12'hA5C};  // single read
    tbl[1] = '{1'b0, 12'h3C3, 60, 16, 1'b0, 12'hA5C};  // underrun repeats prior
    tbl[2] = '{1'b1, 12'h123, 10, 16, 1'b1, 12'h000};  // early read: zero frame
    tbl[3] = '{1'b0, 12'h777, 60, 16, 1'b0, 12'h123};  // sample from early start
    tbl[4] = '{1'b1, 12'hFFF, 55,  5, 1'b0, 12'hFFF};  // short frame
    tbl[5] = '{1'b1, 12'h5A5, 50, 16, 1'b0, 12'h5A5};  // full frame after short
    tbl[6] = '{1'b1, 12'h800, CONV + 3, 16, 1'b0, 12'h800};  // minimum cs high
    tbl[7] = '{1'b1, 12'h001, CONV + 3, 16, 1'b0, 12'h001};  // LSB and tail

    bus.cs           = 1'b1;
    bus.sck          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 12'h000;
    reset_n          = 1'b0;
    m_conv           = 12'h000;
    m_out            = 12'h000;

    repeat (3) tick();
    check("reset_miso", {31'd0, bus.miso}, 32'd0);
    check("reset_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
    check("reset_pulses", {29'd0, bus.sample_ready, bus.underrun, bus.early_read}, 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();
    check("idle_miso_oe", {31'd0, bus.miso_oe}, 32'd0);

    // First read after reset returns 0x000
    read_phase(1'b0, 16, got);
    check("first_read_frame", {16'd0, got}, 32'd0);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data, tbl[i].high,
              tbl[i].nbits, 1'b0, tbl[i].early, tbl[i].exp_read);
    end

    // Async reset in the middle of a frame carrying ones
    conv_phase(1'b1, 12'hFFF, 60, dummy);
    bus.cs = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      bus.sck = 1'b1;
      repeat (4) tick();
      bus.sck = 1'b0;
      repeat (4) tick();
    end
    check("pre_reset_miso", {31'd0, bus.miso}, 32'd1);
    r0 = cnt_ready; u0 = cnt_under; e0 = cnt_early;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_miso", {31'd0, bus.miso}, 32'd0);
    check("async_reset_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
    bus.cs = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("reset_no_pulses", (cnt_ready - r0) + (cnt_under - u0) + (cnt_early - e0), 32'd0);
    m_conv = 12'h000;
    m_out  = 12'h000;
    read_phase(1'b0, 16, got);
    check("post_reset_frame", {16'd0, got}, 32'd0);

    // Back-to-back random frames against the model
    for (int i = 0; i < 100; i++) begin
      run_txn($sformatf("rnd%0d", i), ($urandom_range(0, 4) != 0),
              12'($urandom_range(0, 4095)), $urandom_range(CONV + 3, CONV + 24),
              16, 1'b1, 1'b0, 12'h000);
    end

    bus.cs = 1'b1;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ltc2315_emulator.md
# ltc2315_emulator

Synthesizable responder for the LTC2315 12-bit serial ADC read interface: it watches `cs`/`sck` from an external controller and drives `miso` with the framed sample exactly as the real converter would. It is used for hardware-in-the-loop bring-up of the acquisition chain. A sample source, such as a pattern generator or a DMA replay of recorded hydrophone data, sits behind a valid/ready handshake. The block lives in the periphery tree beside the LTC2315 driver. It runs on the fabric clock and treats the controller's pins as asynchronous inputs.

## Interface
- `CONV_CYCLES`, default 44: `clk` cycles from the detected `cs` rise until the conversion is complete (t_CONV emulation); legal range is 1–255.
- `clk` in 1: fabric clock; every flop is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs` in 1: chip select from the controller; active low; asynchronous to `clk`.
- `sck` in 1: serial clock from the controller; asynchronous to `clk`.
- `miso` out 1: serial data to the controller.
- `miso_oe` out 1: output enable for the pad tristate; equal to the synchronized `~cs`.
- `sample_data` in 12: next sample, unsigned.
- `sample_valid` in 1: `sample_data` is offered.
- `sample_ready` out 1: single-cycle pulse that consumes `sample_data`.
- `underrun` out 1: single-cycle pulse; a conversion started with no valid sample.
- `early_read` out 1: single-cycle pulse; `cs` fell before the conversion completed.

## Operation
- `cs` and `sck` each pass through a 2-flop synchronizer, then a third flop for edge detection.
- State machine in `ltc2315_pkg::emu_state_t`:
  - IDLE: `cs` high and conversion done. Synchronized `cs` fall → SHIFT. Synchronized `cs` rise is not possible from this state.
  - SHIFT: `cs` low. Each synchronized `sck` fall advances the bit counter. `cs` rise → CONV, from any bit position; short frames are legal.
  - CONV: down-counter loaded with `CONV_CYCLES-1`; the counter reaching 0 → IDLE. `cs` fall while in CONV → SHIFT with a zero frame, plus an `early_read` pulse.
- Sample capture happens on the cycle that `cs` rise is detected (the conversion start):
  - If `sample_valid` is high: latch `sample_data` into the conversion register and pulse `sample_ready`.
  - Otherwise: keep the previous value and pulse `underrun`.
- On entering IDLE from CONV, the conversion register is copied to the output register. Only this copy makes the value readable.
- Frame on `miso`, 4-bit bit counter `bcnt`, saturating at 15:
  - `bcnt`=0, the value presented at the `cs` fall: leading 0.
  - `bcnt`=1..12: D11..D0, MSB first.
  - `bcnt`≥13: 0.
- Zero frame (after an early read): all bits 0 for the whole frame.
- While `cs` is high, `miso`=0 and `miso_oe`=0.
- Simultaneous detected `cs` fall and `sck` fall: the `cs` fall wins and bit 0 is presented.
- Simultaneous detected `cs` rise and `sck` fall: the `cs` rise wins and `bcnt` is cleared.
- `sample_ready` is never asserted without `sample_valid`.

## Timing
- Reset values:
  - state=IDLE, `bcnt`=0.
  - Conversion register and output register are 0.
  - `miso`=0, `miso_oe`=0, and all pulses are 0.
  - Synchronizers are reset to `cs`=1, `sck`=0.
  - The first read after reset therefore returns 0x000.
- Reset asserted mid-frame or mid-conversion: the block returns to the reset values immediately. No pulse is emitted.
- Pin-to-`miso` latency:
  - 3 `clk` from a pin `sck` fall to the registered `miso` update.
  - 3 `clk` from a pin `cs` fall to `miso_oe`=1 with bit 0.
- Supported SCK: both the high and low phases must be ≥4 `clk`, i.e. f_SCK ≤ f_clk/8. Faster rates are out of contract.
- `cs` high time must be ≥ `CONV_CYCLES`+3 `clk` for a valid read.
- `sample_ready`, `underrun` and `early_read` assert exactly 3 `clk` after the corresponding pin edge and last 1 cycle.

## Structure
- `ltc2315_pkg` holds:
  - `LTC2315_DATA_W`=12, `LTC2315_FRAME_BITS`=14.
  - `emu_state_t` (IDLE, SHIFT, CONV).
  - Constants shared with the driver.
- One sub-module: `ltc2315_pin_sync`. It contains the 2-flop synchronizer, the edge-detect flop and rise/fall outputs, and is instantiated once each for `cs` and `sck`.
- Everything else (FSM, counters, shifter) lives in the top module.

## Test plan
- Single read:
  - Stimulus: `sample_valid`=1 with `sample_data`=0xA5C. Pulse `cs` high for 60 clk, drop it, then run 16 SCK cycles at clk/8.
  - Required: `sample_ready` pulses 3 clk after the `cs` rise, and the 16 bits captured on SCK rises are 0,1010_0101_1100,0,0,0.
- Underrun:
  - Stimulus: `sample_valid`=0 across a conversion.
  - Required: `underrun` pulses once and the readback repeats the prior value (0xA5C).
- Early read:
  - Stimulus: `cs` high for 10 clk with `CONV_CYCLES`=44.
  - Required: `early_read` pulses and the frame reads all zeros. The next conventional read returns the sample latched at that conversion start.
- Short frame:
  - Stimulus: `cs` rises after 5 SCK falls.
  - Required: the next conversion starts normally and the following full frame is correct with `bcnt` restarted.
- Async reset:
  - Stimulus: assert `reset_n` low mid-SHIFT.
  - Required: `miso`=0 and `miso_oe`=0 immediately, and the next read returns 0x000.
- Back-to-back:
  - Stimulus: 100 frames of random samples with random legal `cs`-high times.
  - Required: a scoreboard matches every readback to the sample consumed at the previous conversion start.
